action_collector: RTL and testbench
===================================

ACTION_COLLECTOR -- requirements
Module: action_collector

Interface
REQ-001 SHALL have parameter DB_LIMIT, default 50000: consecutive stable clk cycles required to accept a debounced confirm-button level change.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2000000: clk cycles actionEnable stays high per issued round; sized to span at least one game-clock period.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500000000: wait limit for the second player; used only with ACTION_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  system clock; one clock, all state on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port sw1  input  3  player-1 action selection switches; raw, asynchronous.
REQ-007 SHALL have port cfm1  input  1  player-1 confirm pushbutton; raw, bouncing, high = pressed.
REQ-008 SHALL have port sw2  input  3  player-2 action selection switches.
REQ-009 SHALL have port cfm2  input  1  player-2 confirm pushbutton.
REQ-010 SHALL have port action1  output  3  committed player-1 action to the game stage.
REQ-011 SHALL have port action2  output  3  committed player-2 action to the game stage.
REQ-012 SHALL have port actionEnable  output  1  round-valid strobe to the game stage, stretched to HOLD_CYCLES.
REQ-013 SHALL have port ready1  output  1  player-1 committed in the current round (LED).
REQ-014 SHALL have port ready2  output  1  player-2 committed in the current round (LED).

Function
REQ-015 SHALL pass each sw and cfm input through a two-flop synchronizer before any use.
REQ-016 SHALL debounce each synchronized cfm: debounced level changes only after the raw level differs from it for DB_LIMIT consecutive cycles; any bounce restarts the count.
REQ-017 SHALL detect a commit as a debounced 0->1 cfm edge, one cycle wide.
REQ-018 SHALL latch the synchronized sw value of a player on that player's commit into its action register and set its ready flag.
REQ-019 SHALL ignore further commits and sw changes of an already-ready player until the round completes (first value wins).
REQ-020 SHALL implement FSM states IDLE, WAIT, ISSUE, RELEASE.
REQ-021 IDLE: no player ready; one commit -> WAIT; both commits same cycle -> ISSUE.
REQ-022 WAIT: exactly one ready; other player's commit -> ISSUE on the next cycle.
REQ-023 ISSUE: actionEnable=1, action1/action2 stable, hold counter runs; after HOLD_CYCLES cycles -> RELEASE with actionEnable=0.
REQ-024 RELEASE: clear ready1/ready2; -> IDLE only when both debounced cfm levels are 0, so a held button never double-commits.
REQ-025 SHALL keep action1/action2 at their last committed values outside ISSUE; they change only on commit.
REQ-026 SHALL deassert actionEnable for at least one cycle between consecutive rounds.
REQ-027 SHALL use counters just wide enough for their parameter and saturate rather than wrap.

Reset
REQ-028 SHALL asynchronously, on reset=1: state IDLE; action1=3'b000, action2=3'b000, actionEnable=0, ready1=0, ready2=0; all debounced levels 0; all counters 0.
REQ-029 SHALL on reset during ISSUE drop actionEnable immediately, without waiting for clk.
REQ-030 SHALL resume normal operation on the first clk edge after reset deasserts.

Configuration
REQ-031 With ACTION_TIMEOUT_EN defined: a counter runs in WAIT; after TIMEOUT_CYCLES without the second commit, the missing player's action is forced to 3'b000 (idle), its ready flag is set, and the FSM enters ISSUE.
REQ-032 Without ACTION_TIMEOUT_EN: WAIT persists indefinitely; no timeout counter logic is synthesized.

Verification (DB_LIMIT=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=20)
REQ-033 sw1=3'b010 with cfm1 pulse of 6 cycles, then sw2=3'b101 with cfm2 pulse of 6 cycles -> ready1 then ready2; actionEnable high exactly 8 cycles with action1=010, action2=101.
REQ-034 cfm1 toggling every 2 cycles for 20 cycles, then released -> no commit, ready1 stays 0.
REQ-035 Both cfm pressed in the same cycle with sw1=001, sw2=100 -> ISSUE entered directly; actionEnable high 8 cycles.
REQ-036 Player 1 commits 011, then sw1 changes to 110 with a second press before player 2 commits -> action1 stays 011 at issue.
REQ-037 cfm1 held through ISSUE and RELEASE -> no new round until cfm1 released and debounced low.
REQ-038 reset asserted mid-ISSUE between clk edges -> actionEnable, ready flags and actions go 0 asynchronously; with ACTION_TIMEOUT_EN, lone player-1 commit -> after 20 WAIT cycles action2=000 and actionEnable rises.

Source files
------------

// File: rtl/action_collector.sv
// Two-player action collector: synchronizes and debounces the confirm buttons, gathers one
// action per player per round and strobes them to the game stage. Option macro: ACTION_TIMEOUT_EN.
module action_collector #(
    parameter int DB_LIMIT       = 50000,
    parameter int HOLD_CYCLES    = 2000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw1,
    input  logic       cfm1,
    input  logic [2:0] sw2,
    input  logic       cfm2,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       actionEnable,
    output logic       ready1,
    output logic       ready2
);

    localparam int DB_W   = $clog2(DB_LIMIT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RELEASE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        sw1_meta_reg, sw1_sync_reg, sw2_meta_reg, sw2_sync_reg;
    logic [1:0]        cfm_meta_reg, cfm_sync_reg;
    logic [1:0]        db_level;
    logic [1:0]        commit;
    logic [2:0]        action1_reg, action1_next, action2_reg, action2_next;
    logic              ready1_reg, ready1_next, ready2_reg, ready2_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw1_meta_reg <= '0;
            sw1_sync_reg <= '0;
            sw2_meta_reg <= '0;
            sw2_sync_reg <= '0;
            cfm_meta_reg <= '0;
            cfm_sync_reg <= '0;
        end else begin
            sw1_meta_reg <= sw1;
            sw1_sync_reg <= sw1_meta_reg;
            sw2_meta_reg <= sw2;
            sw2_sync_reg <= sw2_meta_reg;
            cfm_meta_reg <= {cfm2, cfm1};
            cfm_sync_reg <= cfm_meta_reg;
        end
    end

    // Per-player debouncer; the commit strobe fires on the cycle the level turns 1.
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic [DB_W-1:0] cnt_reg;
        logic            level_reg;
        logic            rise_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg   <= '0;
                level_reg <= 1'b0;
                rise_reg  <= 1'b0;
            end else begin
                rise_reg <= 1'b0;
                if (cfm_sync_reg[gi] != level_reg) begin
                    if (cnt_reg == DB_LAST) begin
                        level_reg <= cfm_sync_reg[gi];
                        rise_reg  <= cfm_sync_reg[gi];
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end
        end

        assign db_level[gi] = level_reg;
        assign commit[gi]   = rise_reg;
    end

`ifdef ACTION_TIMEOUT_EN
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] timeout_cnt_reg, timeout_cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt_reg <= '0;
        end else begin
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end
`else
    // No timeout hardware in this build; the parameter stays for a uniform interface.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            action1_reg  <= '0;
            action2_reg  <= '0;
            ready1_reg   <= 1'b0;
            ready2_reg   <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            action1_reg  <= action1_next;
            action2_reg  <= action2_next;
            ready1_reg   <= ready1_next;
            ready2_reg   <= ready2_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        action1_next  = action1_reg;
        action2_next  = action2_reg;
        ready1_next   = ready1_reg;
        ready2_next   = ready2_reg;
        hold_cnt_next = '0;
`ifdef ACTION_TIMEOUT_EN
        timeout_cnt_next = '0;
`endif
        case (state_reg)
            IDLE: begin
                if (commit[0]) begin
                    action1_next = sw1_sync_reg;
                    ready1_next  = 1'b1;
                end
                if (commit[1]) begin
                    action2_next = sw2_sync_reg;
                    ready2_next  = 1'b1;
                end
                if (commit[0] && commit[1]) begin
                    state_next = ISSUE;
                end else if (commit[0] || commit[1]) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Only the player still missing may commit; the ready one keeps its first value.
                if (commit[0] && !ready1_reg) begin
                    action1_next = sw1_sync_reg;
                    ready1_next  = 1'b1;
                    state_next   = ISSUE;
                end else if (commit[1] && !ready2_reg) begin
                    action2_next = sw2_sync_reg;
                    ready2_next  = 1'b1;
                    state_next   = ISSUE;
                end
`ifdef ACTION_TIMEOUT_EN
                else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    if (!ready1_reg) begin
                        action1_next = 3'b000;
                        ready1_next  = 1'b1;
                    end else begin
                        action2_next = 3'b000;
                        ready2_next  = 1'b1;
                    end
                    state_next = ISSUE;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + 1'b1;
                end
`endif
            end
            ISSUE: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next  = RELEASE;
                    ready1_next = 1'b0;
                    ready2_next = 1'b0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RELEASE: begin
                if (!db_level[0] && !db_level[1]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Enable decodes straight from the state register so reset clears it without a clock.
    assign actionEnable = (state_reg == ISSUE);
    assign action1      = action1_reg;
    assign action2      = action2_reg;
    assign ready1       = ready1_reg;
    assign ready2       = ready2_reg;

endmodule

// File: tb/tb_action_collector.sv
// Self-checking bench for action_collector: a round-level reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized press phase.
module tb_action_collector;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sw1 = 3'b000;
    logic [2:0] sw2 = 3'b000;
    logic       cfm1 = 1'b0;
    logic       cfm2 = 1'b0;
    logic [2:0] action1, action2;
    logic       actionEnable, ready1, ready2;

    always #5 clk = ~clk;

    action_collector #(
        .DB_LIMIT(DB),
        .HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw1(sw1),
        .cfm1(cfm1),
        .sw2(sw2),
        .cfm2(cfm2),
        .action1(action1),
        .action2(action2),
        .actionEnable(actionEnable),
        .ready1(ready1),
        .ready2(ready2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: pipelines, sliding-window debounce, and round bookkeeping by counters.
    bit         m_meta_c[2], m_sync_c[2];
    logic [2:0] m_meta_sw[2], m_sync_sw[2];
    bit         m_level[2], m_rise[2];
    bit         m_hist[2][DB];
    bit         m_r1, m_r2, m_rel;
    logic [2:0] m_a1, m_a2;
    int         m_en_left, m_age;

    always @(posedge clk or posedge reset) begin : model
        bit         nr1, nr2, nrel, allb;
        logic [2:0] na1, na2;
        int         nen, nage;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_meta_c[i]  <= 1'b0;
                m_sync_c[i]  <= 1'b0;
                m_meta_sw[i] <= 3'b000;
                m_sync_sw[i] <= 3'b000;
                m_level[i]   <= 1'b0;
                m_rise[i]    <= 1'b0;
                for (int k = 0; k < DB; k++) m_hist[i][k] <= 1'b0;
            end
            m_r1 <= 1'b0; m_r2 <= 1'b0; m_rel <= 1'b0;
            m_a1 <= 3'b000; m_a2 <= 3'b000;
            m_en_left <= 0; m_age <= 0;
        end else begin
            nr1 = m_r1; nr2 = m_r2; na1 = m_a1; na2 = m_a2;
            nen = m_en_left; nrel = m_rel; nage = m_age;
            if (nen > 0) begin
                nen--;
                if (nen == 0) begin
                    nrel = 1'b1; nr1 = 1'b0; nr2 = 1'b0;
                end
            end else if (nrel) begin
                if (!m_level[0] && !m_level[1]) nrel = 1'b0;
            end else begin
`ifdef ACTION_TIMEOUT_EN
                bit was_wait;
                was_wait = m_r1 ^ m_r2;
`endif
                if (m_rise[0] && !nr1) begin nr1 = 1'b1; na1 = m_sync_sw[0]; end
                if (m_rise[1] && !nr2) begin nr2 = 1'b1; na2 = m_sync_sw[1]; end
                if (nr1 && nr2) begin
                    nen = HOLD; nage = 0;
                end
`ifdef ACTION_TIMEOUT_EN
                else if (was_wait) begin
                    if (nage == TMO - 1) begin
                        if (!nr1) begin na1 = 3'b000; nr1 = 1'b1; end
                        else begin na2 = 3'b000; nr2 = 1'b1; end
                        nen = HOLD; nage = 0;
                    end else begin
                        nage++;
                    end
                end
`endif
            end
            for (int i = 0; i < 2; i++) begin
                allb = (m_sync_c[i] != m_level[i]);
                for (int k = 1; k < DB; k++) begin
                    m_hist[i][k-1] <= m_hist[i][k];
                    if (m_hist[i][k] == m_level[i]) allb = 1'b0;
                end
                m_hist[i][DB-1] <= m_sync_c[i];
                m_level[i]  <= allb ? m_sync_c[i] : m_level[i];
                m_rise[i]   <= allb && m_sync_c[i];
                m_sync_c[i] <= m_meta_c[i];
                m_sync_sw[i] <= m_meta_sw[i];
            end
            m_meta_c[0] <= cfm1;  m_meta_c[1] <= cfm2;
            m_meta_sw[0] <= sw1;  m_meta_sw[1] <= sw2;
            m_r1 <= nr1; m_r2 <= nr2; m_a1 <= na1; m_a2 <= na2;
            m_en_left <= nen; m_rel <= nrel; m_age <= nage;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_action1", action1, m_a1);
            check("cyc_action2", action2, m_a2);
            check("cyc_enable", actionEnable, m_en_left > 0);
            check("cyc_ready1", ready1, m_r1);
            check("cyc_ready2", ready2, m_r2);
        end
    end

    task automatic press(input int p, input int len);
        if (p == 0) cfm1 = 1'b1; else cfm2 = 1'b1;
        repeat (len) @(negedge clk);
        if (p == 0) cfm1 = 1'b0; else cfm2 = 1'b0;
    endtask

    task automatic watch(input int n, output int en_cyc, output int rises,
                         output logic [2:0] c1, output logic [2:0] c2,
                         output int t_r1, output int t_r2, output int wait_cyc);
        logic prev;
        en_cyc = 0; rises = 0; c1 = 3'bxxx; c2 = 3'bxxx;
        t_r1 = -1; t_r2 = -1; wait_cyc = 0;
        prev = actionEnable;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (actionEnable) begin
                en_cyc++;
                c1 = action1;
                c2 = action2;
                if (!prev) rises++;
            end
            if (ready1 && t_r1 < 0) t_r1 = i;
            if (ready2 && t_r2 < 0) t_r2 = i;
            if ((ready1 ^ ready2) && !actionEnable) wait_cyc++;
            prev = actionEnable;
        end
    endtask

    int         en, ri, tr1, tr2, wc;
    logic [2:0] c1, c2;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_action1", action1, 3'b000);
        check("rst_action2", action2, 3'b000);
        check("rst_enable", actionEnable, 0);
        check("rst_ready1", ready1, 0);
        check("rst_ready2", ready2, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Sequential commits
        sw1 = 3'b010;
        fork
            begin press(0, 6); repeat (10) @(negedge clk); sw2 = 3'b101; press(1, 6); end
            watch(70, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("seq_en_cycles", en, HOLD);
        check("seq_rises", ri, 1);
        check("seq_action1", c1, 3'b010);
        check("seq_action2", c2, 3'b101);
        check("seq_ready_order", (tr1 >= 0) && (tr1 < tr2), 1);

        // Bouncing button never commits
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    cfm1 = 1'b1; repeat (2) @(negedge clk);
                    cfm1 = 1'b0; repeat (2) @(negedge clk);
                end
            end
            watch(40, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("bounce_rises", ri, 0);
        check("bounce_ready1", tr1, -1);

        // Simultaneous commits
        sw1 = 3'b001; sw2 = 3'b100;
        repeat (3) @(negedge clk);
        fork
            press(0, 6);
            press(1, 6);
            watch(40, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("sim_en_cycles", en, HOLD);
        check("sim_rises", ri, 1);
        check("sim_action1", c1, 3'b001);
        check("sim_action2", c2, 3'b100);
        check("sim_ready_same", tr1 == tr2, 1);

        // First value wins
        sw1 = 3'b011; sw2 = 3'b111;
        repeat (3) @(negedge clk);
        fork
            begin
                press(0, 6); repeat (2) @(negedge clk);
                sw1 = 3'b110; repeat (4) @(negedge clk);
                press(0, 6);
            end
            begin repeat (16) @(negedge clk); press(1, 6); end
            watch(70, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("first_rises", ri, 1);
        check("first_action1", c1, 3'b011);
        check("first_action2", c2, 3'b111);

        // Held button blocks the next round
        sw1 = 3'b101; sw2 = 3'b010;
        repeat (3) @(negedge clk);
        fork
            begin cfm1 = 1'b1; repeat (60) @(negedge clk); end
            begin repeat (10) @(negedge clk); press(1, 6); end
            watch(60, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("hold_rises", ri, 1);
        check("hold_en_cycles", en, HOLD);
        check("hold_ready1_after", ready1, 0);
        check("hold_enable_after", actionEnable, 0);
        cfm1 = 1'b0;
        watch(30, en, ri, c1, c2, tr1, tr2, wc);
        check("hold_release_rises", ri, 0);
        check("hold_release_ready1", tr1, -1);

        // Lone player
        sw1 = 3'b011; sw2 = 3'b110;
        repeat (3) @(negedge clk);
`ifdef ACTION_TIMEOUT_EN
        fork
            press(0, 6);
            watch(60, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("tmo_wait_cycles", wc, TMO);
        check("tmo_rises", ri, 1);
        check("tmo_en_cycles", en, HOLD);
        check("tmo_action1", c1, 3'b011);
        check("tmo_action2", c2, 3'b000);
`else
        fork
            press(0, 6);
            watch(60, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("lone_rises", ri, 0);
        check("lone_ready1", ready1, 1);
        check("lone_ready2", tr2, -1);
        fork
            press(1, 6);
            watch(40, en, ri, c1, c2, tr1, tr2, wc);
        join
        check("lone_done_rises", ri, 1);
        check("lone_done_action1", c1, 3'b011);
        check("lone_done_action2", c2, 3'b110);
`endif

        // Randomized presses, bounces and switch changes
        for (int it = 0; it < 40; it++) begin
            int d1, d2, l1, l2;
            bit u1, u2;
            d1 = $urandom_range(0, 12); d2 = $urandom_range(0, 12);
            l1 = $urandom_range(1, 10); l2 = $urandom_range(1, 10);
            u1 = ($urandom_range(0, 3) != 0); u2 = ($urandom_range(0, 3) != 0);
            sw1 = 3'($urandom_range(0, 7));
            sw2 = 3'($urandom_range(0, 7));
            fork
                begin repeat (d1) @(negedge clk); if (u1) press(0, l1); end
                begin repeat (d2) @(negedge clk); if (u2) press(1, l2); end
                begin repeat (5) @(negedge clk); sw1 = 3'($urandom_range(0, 7)); end
            join
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        // Asynchronous reset in the middle of a round
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sw1 = 3'b111; sw2 = 3'b110;
        repeat (3) @(negedge clk);
        fork
            press(0, 6);
            press(1, 6);
        join
        begin
            int k;
            k = 0;
            while (!actionEnable && k < 40) begin
                @(negedge clk);
                k++;
            end
        end
        check("arst_issue_seen", actionEnable, 1);
        repeat (2) @(negedge clk);
        check("arst_pre_action1", action1, 3'b111);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_enable", actionEnable, 0);
        check("arst_ready1", ready1, 0);
        check("arst_ready2", ready2, 0);
        check("arst_action1", action1, 3'b000);
        check("arst_action2", action2, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
